// File: rtl/lsq_pkg.sv
// lsq_pkg: shared configuration, operand types and queue entry layout for the load/store queue.
package lsq_pkg;
  localparam int LSQ_DEPTH_CFG = 8;
  localparam int BRU_BITS = 2;
  localparam int ROB_BITS = 4;
  typedef logic [$clog2(LSQ_DEPTH_CFG)-1:0] lsq_ent_t;
  typedef logic [2**BRU_BITS-1:0] br_mask_t;
  typedef logic [ROB_BITS-1:0] rob_ent_t;
  typedef logic [4:0] rreg_t;
  typedef logic [5:0] preg_t;
  typedef enum logic [2:0] {
    LSF_B  = 3'b000,
    LSF_H  = 3'b001,
    LSF_W  = 3'b010,
    LSF_BU = 3'b100,
    LSF_HU = 3'b101
  } load_store_f3_t;
  typedef enum logic {IDLE, WAIT_RESP} lsq_state_t;
  typedef struct packed {
    logic valid;
    logic addr_valid;
    logic committed;
    logic is_str;
    br_mask_t br_mask;
    logic [31:0] addr;
    load_store_f3_t f3;
    logic [31:0] str_val;
    rob_ent_t rob_idx;
    rreg_t rd;
    preg_t pd;
  } lsq_entry_t;
endpackage

// File: rtl/lsq_align.sv
// lsq_align: byte-lane mask, store data shift and load extraction/extension.
module lsq_align
  import lsq_pkg::*;
(
  input  load_store_f3_t f3,
  input  logic [1:0]     lane,
  input  logic [31:0]    str_val,
  input  logic [31:0]    rdata,
  output logic [3:0]     mask,
  output logic [31:0]    wdata,
  output logic [31:0]    ld_data
);
  logic [31:0] sh;
  always_comb begin
    mask = (f3[1:0] == 2'b00 ? 4'b0001 : f3[1:0] == 2'b01 ? 4'b0011 : 4'b1111) << lane;
    wdata = str_val << {lane, 3'b000};
    sh = rdata >> {lane, 3'b000};
    ld_data = f3 == LSF_B  ? {{24{sh[7]}}, sh[7:0]} :
              f3 == LSF_H  ? {{16{sh[15]}}, sh[15:0]} :
              f3 == LSF_BU ? {24'b0, sh[7:0]} :
              f3 == LSF_HU ? {16'b0, sh[15:0]} : sh;
  end
endmodule

// File: rtl/lsq.sv
// lsq: circular in-order load/store queue issuing one memory request at a time from its head,
// with branch-mask based squashing of the young suffix.
module lsq
  import lsq_pkg::*;
#(
  parameter int LSQ_DEPTH = LSQ_DEPTH_CFG,
  parameter int LSQ_BITS = $clog2(LSQ_DEPTH)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                alloc_valid,
  input  logic                alloc_is_str,
  input  br_mask_t            alloc_br_mask,
  output logic                alloc_ready,
  output logic [LSQ_BITS-1:0] alloc_idx,
  input  logic                ex_valid,
  input  logic [LSQ_BITS-1:0] ex_lsq_idx,
  input  logic [31:0]         ex_addr,
  input  load_store_f3_t      ex_ld_str_type,
  input  logic                ex_is_str,
  input  logic [31:0]         ex_str_val,
  input  rob_ent_t            ex_rob_idx,
  input  rreg_t               ex_rd,
  input  preg_t               ex_pd,
  input  logic                commit_str,
  input  logic                br_valid,
  input  logic                br_mispred,
  input  logic [BRU_BITS-1:0] br_idx,
  output logic [31:0]         dmem_addr,
  output logic [3:0]          dmem_rmask,
  output logic [3:0]          dmem_wmask,
  output logic [31:0]         dmem_wdata,
  input  logic [31:0]         dmem_rdata,
  input  logic                dmem_resp,
  output logic                deq_done,
  output logic [31:0]         deq_ld_data,
  output rreg_t               deq_rd,
  output preg_t               deq_pd,
  output rob_ent_t            deq_rob_idx,
  output logic                st_done,
  output rob_ent_t            st_done_rob_idx
);
  lsq_entry_t q [LSQ_DEPTH];
  lsq_state_t state, state_n;
  logic [LSQ_BITS-1:0] head, tail, k_off;
  logic [LSQ_BITS:0] count;
  logic [LSQ_DEPTH-1:0] kill;
  logic drop, mis, any_kill, kill_head, alloc_acc, ex_ok, go, pop, act;
  br_mask_t clr_mask;
  logic [31:0] req_addr, req_str_val, a_addr, a_sv, mask_w, wdata, ld_data;
  load_store_f3_t req_f3, a_f3;
  logic req_is_str, a_str;
  logic [3:0] mask;
  always_comb begin
    mis = br_valid & br_mispred;
    clr_mask = (br_valid & ~br_mispred) ? br_mask_t'(1) << br_idx : '0;
    for (int i = 0; i < LSQ_DEPTH; i++) kill[i] = mis & q[i].valid & q[i].br_mask[br_idx];
    any_kill = |kill;
    k_off = '0;
    for (int i = LSQ_DEPTH - 1; i >= 0; i--) if (kill[head + LSQ_BITS'(i)]) k_off = LSQ_BITS'(i);
    kill_head = kill[head];
    alloc_ready = (count != (LSQ_BITS + 1)'(LSQ_DEPTH)) & ~mis;
    alloc_idx = tail;
    alloc_acc = alloc_valid & alloc_ready;
    ex_ok = ex_valid & q[ex_lsq_idx].valid & ~kill[ex_lsq_idx];
    go = (state == IDLE) & q[head].valid & q[head].addr_valid &
         (~q[head].is_str | q[head].committed) & ~kill_head;
    pop = (state == WAIT_RESP) & dmem_resp & ~drop & ~kill_head;
    state_n = go ? WAIT_RESP : ((state == WAIT_RESP) & dmem_resp) ? IDLE : state;
    act = go | (state == WAIT_RESP);
    a_addr = go ? q[head].addr : req_addr;
    a_sv = go ? q[head].str_val : req_str_val;
    a_f3 = go ? q[head].f3 : req_f3;
    a_str = go ? q[head].is_str : req_is_str;
    mask_w = {28'b0, mask};
    dmem_addr = act ? {a_addr[31:2], 2'b00} : '0;
    dmem_rmask = (act & ~a_str) ? mask_w[3:0] : '0;
    dmem_wmask = (act & a_str) ? mask_w[3:0] : '0;
    dmem_wdata = (act & a_str) ? wdata : '0;
    deq_done = pop & ~req_is_str;
    deq_ld_data = deq_done ? ld_data : '0;
    deq_rd = deq_done ? q[head].rd : '0;
    deq_pd = deq_done ? q[head].pd : '0;
    deq_rob_idx = deq_done ? q[head].rob_idx : '0;
    st_done = ex_ok & ex_is_str;
    st_done_rob_idx = st_done ? ex_rob_idx : '0;
  end
  lsq_align u_align (
    .f3(a_f3), .lane(a_addr[1:0]), .str_val(a_sv), .rdata(dmem_rdata),
    .mask(mask), .wdata(wdata), .ld_data(ld_data)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      drop <= 1'b0;
      head <= '0;
      tail <= '0;
      count <= '0;
      req_addr <= '0;
      req_str_val <= '0;
      req_f3 <= LSF_B;
      req_is_str <= 1'b0;
      for (int i = 0; i < LSQ_DEPTH; i++) begin
        q[i].valid <= 1'b0;
        q[i].addr_valid <= 1'b0;
        q[i].committed <= 1'b0;
      end
    end else begin
      state <= state_n;
      drop <= (state == WAIT_RESP) & ~dmem_resp & (drop | kill_head);
      head <= head + LSQ_BITS'(pop);
      // Killed entries are always the youngest run, so the oldest kill becomes the new tail.
      if (mis & any_kill) begin
        tail <= head + k_off;
        count <= (LSQ_BITS + 1)'(k_off) - (LSQ_BITS + 1)'(pop);
      end else begin
        tail <= tail + LSQ_BITS'(alloc_acc);
        count <= count + (LSQ_BITS + 1)'(alloc_acc) - (LSQ_BITS + 1)'(pop);
      end
      if (go) begin
        req_addr <= q[head].addr;
        req_str_val <= q[head].str_val;
        req_f3 <= q[head].f3;
        req_is_str <= q[head].is_str;
      end
      for (int i = 0; i < LSQ_DEPTH; i++) begin
        q[i].br_mask <= q[i].br_mask & ~clr_mask;
        if (kill[i]) q[i].valid <= 1'b0;
      end
      if (ex_ok) begin
        q[ex_lsq_idx].addr <= ex_addr;
        q[ex_lsq_idx].f3 <= ex_ld_str_type;
        q[ex_lsq_idx].str_val <= ex_str_val;
        q[ex_lsq_idx].rob_idx <= ex_rob_idx;
        q[ex_lsq_idx].rd <= ex_rd;
        q[ex_lsq_idx].pd <= ex_pd;
        q[ex_lsq_idx].addr_valid <= 1'b1;
      end
      if (commit_str & q[head].valid & q[head].is_str) q[head].committed <= 1'b1;
      if (pop) q[head].valid <= 1'b0;
      if (alloc_acc) begin
        q[tail].valid <= 1'b1;
        q[tail].addr_valid <= 1'b0;
        q[tail].committed <= 1'b0;
        q[tail].is_str <= alloc_is_str;
        q[tail].br_mask <= alloc_br_mask & ~clr_mask;
      end
    end
  end
endmodule
